// File: rtl/wb_pkg.sv
// Shared types for the register writeback stage.
// Register address/data widths, FIFO entry and arbiter states.
package wb_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  typedef enum logic [0:0] {
    ALU_PRI = 1'b0,
    DRAIN   = 1'b1
  } arb_state_e;

  function automatic logic [XLEN-1:0] rd_bit(
    input logic [REG_AW-1:0] rd
  );
    logic [XLEN-1:0] m;
    m = '0;
    if (rd != '0) m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Writeback bundle: ALU result, load handshake, register-file port.
// The stage itself uses the slave modport.
interface wb_if;
  import wb_pkg::*;

  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              alu_stall;

  logic              ld_valid;
  logic              ld_ready;
  logic [REG_AW-1:0] ld_rd;
  logic [XLEN-1:0]   ld_data;

  logic              RegWrite;
  logic [REG_AW-1:0] WriteAddr;
  logic [XLEN-1:0]   WriteData;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    input  alu_stall, ld_ready,
    input  RegWrite, WriteAddr, WriteData
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    output alu_stall, ld_ready,
    output RegWrite, WriteAddr, WriteData
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries (load/mul results).
// WB_PENDING_EN adds rd_mask: destinations of all held entries.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
`ifdef WB_PENDING_EN
  ,
  output logic [XLEN-1:0] rd_mask
`endif
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t    mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         do_push;
  logic         do_pop;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop)  rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

`ifdef WB_PENDING_EN
  logic [AW:0] cnt;
  logic [AW:0] idx;

  assign cnt = wp - rp;

  always_comb begin
    rd_mask = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rp + (AW+1)'(i);
      if ((AW+1)'(i) < cnt)
        rd_mask = rd_mask |
                  rd_bit(mem[idx[AW-1:0]].rd);
    end
  end
`endif

endmodule

// File: rtl/reg_writeback.sv
// Writeback arbiter: ALU results vs. buffered load results.
// Optional WB_PENDING_EN exposes pend_mask of in-flight writes.
module reg_writeback
  import wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  wb_if.slave             wb
`ifdef WB_PENDING_EN
  ,
  output logic [XLEN-1:0] pend_mask
`endif
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  arb_state_e        state;
  arb_state_e        state_d;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_d;

  wb_entry_t         ld_in;
  wb_entry_t         head;
  wb_entry_t         win;
  logic              full;
  logic              empty;
  logic              drain;
  logic              alu_win;
  logic              fifo_win;
  logic              any_win;

  logic              wr_en;
  logic [REG_AW-1:0] wr_addr;
  logic [XLEN-1:0]   wr_data;

  assign ld_in.rd   = wb.ld_rd;
  assign ld_in.data = wb.ld_data;

`ifdef WB_PENDING_EN
  logic [XLEN-1:0] fifo_mask;
`endif

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wb.ld_valid),
    .pop   (fifo_win),
    .din   (ld_in),
    .head  (head),
    .full  (full),
    .empty (empty)
`ifdef WB_PENDING_EN
    ,
    .rd_mask (fifo_mask)
`endif
  );

  assign drain    = (state == DRAIN);
  assign alu_win  = !drain && wb.alu_valid;
  assign fifo_win = !empty &&
                    (drain || !wb.alu_valid);
  assign any_win  = alu_win || fifo_win;

  // ld_ready depends only on FIFO pointers
  assign wb.ld_ready  = !full;
  assign wb.alu_stall = drain && wb.alu_valid;

  always_comb begin
    win = head;
    if (alu_win) begin
      win.rd   = wb.alu_rd;
      win.data = wb.alu_data;
    end
  end

  // Starvation counts ALU wins over a waiting load
  always_comb begin
    cnt_d   = cnt;
    state_d = state;
    unique case (state)
      DRAIN: begin
        cnt_d   = '0;
        state_d = ALU_PRI;
      end
      default: begin
        if (empty || fifo_win) begin
          cnt_d = '0;
        end else if (alu_win) begin
          cnt_d = cnt + CW'(1);
          if (cnt_d == CW'(STARVE_LIMIT))
            state_d = DRAIN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ALU_PRI;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= any_win && (win.rd != '0);
      if (any_win) begin
        wr_addr <= win.rd;
        wr_data <= win.data;
      end
    end
  end

  assign wb.RegWrite  = wr_en;
  assign wb.WriteAddr = wr_addr;
  assign wb.WriteData = wr_data;

`ifdef WB_PENDING_EN
  assign pend_mask = fifo_mask |
                     (wr_en ? rd_bit(wr_addr) : '0);
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Randomized bench for reg_writeback against a queue-based model.
// Define WB_PENDING_EN to also check pend_mask.
module tb_reg_writeback;
  import wb_pkg::*;

  localparam int LIMIT = 4;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_if wb ();

`ifdef WB_PENDING_EN
  logic [31:0] pend_mask;
`endif

  reg_writeback #(
    .STARVE_LIMIT (LIMIT),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb)
`ifdef WB_PENDING_EN
    ,
    .pend_mask (pend_mask)
`endif
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          starve;
  bit          m_drain;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_known;

  task automatic m_reset();
    q.delete();
    starve  = 0;
    m_drain = 0;
    m_we    = 0;
    m_addr  = '0;
    m_data  = '0;
    m_known = 1;
  endtask

  task automatic drive(bit av, logic [4:0] ar,
                       logic [31:0] ad, bit lv,
                       logic [4:0] lr, logic [31:0] ld);
    wb.alu_valid = av;
    wb.alu_rd    = ar;
    wb.alu_data  = ad;
    wb.ld_valid  = lv;
    wb.ld_rd     = lr;
    wb.ld_data   = ld;
  endtask

  task automatic step(bit av, logic [4:0] ar,
                      logic [31:0] ad, bit lv,
                      logic [4:0] lr, logic [31:0] ld,
                      output bit st, output bit rdy);
    bit          ne;
    bit          full;
    bit          from_q;
    bit          has_w;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] pm;
    ent_t        e;
    @(negedge clk);
    drive(av, ar, ad, lv, lr, ld);
    #1;
    st   = wb.alu_stall;
    rdy  = wb.ld_ready;
    ne   = (q.size() != 0);
    full = (q.size() == DEPTH);
    chk("alu_stall", st, m_drain && av);
    chk("ld_ready", rdy, !full);
    chk("RegWrite", wb.RegWrite, m_we);
    if (m_known) begin
      chk("WriteAddr", wb.WriteAddr, m_addr);
      chk("WriteData", wb.WriteData, m_data);
    end
    pm = '0;
    foreach (q[i]) if (q[i].rd != 0) pm[q[i].rd] = 1'b1;
    if (m_we) pm[m_addr] = 1'b1;
`ifdef WB_PENDING_EN
    chk("pend_mask", pend_mask, pm);
`endif
    from_q = 0;
    has_w  = 0;
    wr     = '0;
    wd     = '0;
    if (m_drain) begin
      from_q = ne;
    end else if (av) begin
      has_w = 1;
      wr    = ar;
      wd    = ad;
    end else begin
      from_q = ne;
    end
    if (from_q) begin
      e     = q.pop_front();
      has_w = 1;
      wr    = e.rd;
      wd    = e.data;
    end
    if (m_drain) begin
      starve  = 0;
      m_drain = 0;
    end else if (!ne || from_q) begin
      starve = 0;
    end else if (av) begin
      starve++;
      if (starve == LIMIT) m_drain = 1;
    end
    if (lv && !full) begin
      e.rd   = lr;
      e.data = ld;
      q.push_back(e);
    end
    if (has_w) begin
      m_we    = (wr != 0);
      m_addr  = wr;
      m_data  = wd;
      m_known = (wr != 0);
    end else begin
      m_we = 0;
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_RegWrite", wb.RegWrite, 0);
    chk("rst_WriteAddr", wb.WriteAddr, 0);
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ld_ready", wb.ld_ready, 1);
  endtask

  bit          st;
  bit          rdy;
  bit          av;
  bit          lv;
  logic [4:0]  ar;
  logic [4:0]  lr;
  logic [31:0] ad;
  logic [31:0] ld;

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    m_reset();
    #1;
    chk("init_RegWrite", wb.RegWrite, 0);
    chk("init_WriteData", wb.WriteData, 0);
    chk("init_ld_ready", wb.ld_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU only: write lands one cycle later
    step(1, 5, 32'h1234, 0, 0, 0, st, rdy);
    after_edge();
    chk("alu_we", wb.RegWrite, 1);
    chk("alu_addr", wb.WriteAddr, 5);
    chk("alu_data", wb.WriteData, 32'h1234);

    // Load only: no bypass, write two cycles later
    step(0, 0, 0, 1, 7, 32'hDEADBEEF, st, rdy);
    after_edge();
    chk("ld_nobypass", wb.RegWrite, 0);
    step(0, 0, 0, 0, 0, 0, st, rdy);
    after_edge();
    chk("ld_we", wb.RegWrite, 1);
    chk("ld_addr", wb.WriteAddr, 7);
    chk("ld_data", wb.WriteData, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 0, st, rdy);

    // Starvation then one DRAIN cycle
    do_reset();
    step(1, 1, 32'h11, 1, 9, 32'h99, st, rdy);
    for (int k = 2; k <= 5; k++) begin
      step(1, 5'(k), 32'(k), 0, 0, 0, st, rdy);
      chk("starve_nostall", st, 0);
      after_edge();
      chk("starve_alu", wb.WriteAddr, 32'(k));
    end
    step(1, 6, 32'h66, 0, 0, 0, st, rdy);
    chk("drain_stall", st, 1);
    after_edge();
    chk("drain_addr", wb.WriteAddr, 9);
    chk("drain_data", wb.WriteData, 32'h99);
    step(1, 6, 32'h66, 0, 0, 0, st, rdy);
    chk("resume_stall", st, 0);
    after_edge();
    chk("resume_addr", wb.WriteAddr, 6);

    // Full FIFO reopens after DRAIN dequeue
    do_reset();
    step(1, 1, 1, 1, 12, 32'hC, st, rdy);
    step(1, 2, 2, 1, 13, 32'hD, st, rdy);
    step(1, 3, 3, 1, 14, 32'hE, st, rdy);
    chk("full_ready", rdy, 0);
    step(1, 4, 4, 1, 14, 32'hE, st, rdy);
    step(1, 5, 5, 1, 14, 32'hE, st, rdy);
    step(1, 8, 8, 1, 14, 32'hE, st, rdy);
    chk("full_drain_stall", st, 1);
    chk("full_drain_ready", rdy, 0);
    step(1, 8, 8, 1, 14, 32'hE, st, rdy);
    chk("full_reopen", rdy, 1);
    repeat (6) step(0, 0, 0, 0, 0, 0, st, rdy);

    // x0 destinations never write
    do_reset();
    step(1, 0, 32'hAA, 1, 0, 32'hBB, st, rdy);
    after_edge();
    chk("x0_alu_we", wb.RegWrite, 0);
    step(0, 0, 0, 0, 0, 0, st, rdy);
    after_edge();
    chk("x0_ld_we", wb.RegWrite, 0);
`ifdef WB_PENDING_EN
    chk("x0_pend", pend_mask[0], 0);
`endif
    step(0, 0, 0, 0, 0, 0, st, rdy);

    // Reset mid-stream with two buffered loads
    step(1, 3, 32'h33, 1, 10, 32'hA0, st, rdy);
    step(1, 4, 32'h44, 1, 11, 32'hB0, st, rdy);
    after_edge();
    chk("pre_rst_we", wb.RegWrite, 1);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0, 0, st, rdy);
      after_edge();
      chk("no_stale", wb.RegWrite, 0);
    end

    // Randomized traffic
    av = 0; lv = 0; ar = 0; lr = 0; ad = 0; ld = 0;
    st = 0; rdy = 1;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        do_reset();
        av = 0; lv = 0; st = 0; rdy = 1;
      end
      if (!(av && st)) begin
        av = ($urandom_range(3) != 0);
        ar = ($urandom_range(7) == 0) ? 5'd0 :
             5'($urandom_range(31));
        ad = $urandom;
      end
      if (!(lv && !rdy)) begin
        lv = ($urandom_range(1) != 0);
        lr = ($urandom_range(7) == 0) ? 5'd0 :
             5'($urandom_range(31));
        ld = $urandom;
      end
      step(av, ar, ad, lv, lr, ld, st, rdy);
    end

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, is the max consecutive cycles ALU may win while load FIFO non-empty.
REQ-002 Parameter FIFO_DEPTH, default 2, is the load-result buffer depth (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 alu_valid  input  1  single-cycle result present this cycle.
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_data  input  32  ALU result.
REQ-008 alu_stall  output  1  ALU result not accepted this cycle; producer holds its inputs.
REQ-009 ld_valid  input  1  long-latency (load/mul) result offered.
REQ-010 ld_ready  output  1  FIFO can accept; transfer when ld_valid && ld_ready.
REQ-011 ld_rd  input  5  load destination register.
REQ-012 ld_data  input  32  load result.
REQ-013 RegWrite  output  1  register-file write enable.
REQ-014 WriteAddr  output  5  register-file write address.
REQ-015 WriteData  output  32  register-file write data.

Function
REQ-016 RegWrite/WriteAddr/WriteData SHALL be registered; an accepted result drives the write port exactly one cycle after acceptance.
REQ-017 One write per cycle; sources: ALU input (direct) or FIFO head.
REQ-018 Arbiter states: ALU_PRI (ALU wins when alu_valid), DRAIN (FIFO head wins, alu_stall=1 if alu_valid).
REQ-019 ALU_PRI: FIFO head written only in cycles with alu_valid=0; starve counter increments on each cycle ALU wins with FIFO non-empty, clears when FIFO empty or head is written.
REQ-020 ALU_PRI -> DRAIN when starve counter reaches STARVE_LIMIT; DRAIN lasts exactly one cycle (writes one FIFO entry), then -> ALU_PRI with counter cleared.
REQ-021 alu_stall SHALL be 1 only in DRAIN with alu_valid=1; otherwise 0.
REQ-022 ld_ready = FIFO not full, registered-state-only (no combinational path from alu_valid or ld_valid).
REQ-023 FIFO full with dequeue in same cycle: ld_ready remains 0 that cycle; new entry accepted next cycle.
REQ-024 FIFO empty with ld handshake in same cycle: entry SHALL NOT bypass to write port; earliest write is one cycle later (two cycles after handshake on write port).
REQ-025 Destination rd=0 from either source: handshake/dequeue completes, RegWrite=0 for that slot, counts as a write for starvation.
REQ-026 Cycles with no winner: RegWrite=0; WriteAddr/WriteData hold previous values.
REQ-027 FIFO order is strict FIFO; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-028 rst_n low SHALL immediately clear RegWrite, WriteAddr, WriteData to 0, FIFO to empty, starve counter to 0, state to ALU_PRI.
REQ-029 Reset mid-operation discards buffered load results; ld_ready=1 from first cycle after deassertion.

Configuration
REQ-030 Macro WB_PENDING_EN: when defined, adds output pend_mask[31:0], bit n=1 while any FIFO entry or the pending write-port slot targets xn (bit 0 always 0); when undefined, port and logic absent, all other behaviour identical.

Structure
REQ-031 Package wb_pkg holds REG_AW=5, XLEN=32, wb_entry_t (rd, data) and arbiter state enum.
REQ-032 Sub-module wb_fifo (synchronous FIFO of wb_entry_t, full/empty, push/pop) instantiated once.

Verification
REQ-033 Reset: rst_n=0 mid-stream with 2 FIFO entries -> RegWrite=0 at once, ld_ready=1 after release, no stale writes.
REQ-034 ALU only: alu_valid, rd=5, data=0x1234 at cycle t -> RegWrite=1, WriteAddr=5, WriteData=0x1234 at t+1.
REQ-035 Load only: ld handshake rd=7, data=0xDEADBEEF at t, ALU idle -> write x7 at t+2.
REQ-036 Starvation: FIFO holds 1 entry, alu_valid held 1 -> 4 ALU writes, then alu_stall=1 for one cycle and FIFO head written, ALU resumes.
REQ-037 Full: ld_valid held 1, alu_valid held 1 -> ld_ready=0 after 2 accepts; reopens the cycle after a DRAIN dequeue.
REQ-038 x0: alu_rd=0 and ld_rd=0 results -> handshakes complete, RegWrite never 1; pend_mask[0]=0 when WB_PENDING_EN.
